// File: rtl/dmem_responder.sv
// Handshaked data-memory target with programmable wait states,
// byte-enable stores and misaligned/out-of-range error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept, commit;

    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    logic        c_we, c_err;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic [IW-1:0] c_idx;

    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-latency commits straight from the request bus.
    assign c_we    = (state == IDLE) ? req_we    : cap_we;
    assign c_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign c_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign c_be    = (state == IDLE) ? req_be    : cap_be;
    assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= DEPTH_LIM);
    assign c_idx   = c_addr[IW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit) begin
                resp_err   <= c_err;
                resp_rdata <= (c_err || c_we) ? 32'd0 : mem[c_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    // A reset on the commit edge aborts the store.
    always_ff @(posedge clk) begin
        if (commit && !rst && !c_err && c_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance plus
// a LATENCY=0 instance for the zero-wait timing case.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        z_valid, z_ready, z_we;
    logic [31:0] z_addr, z_wdata;
    logic [3:0]  z_be;
    logic        z_rvalid, z_rready, z_err;
    logic [31:0] z_rdata;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_valid), .req_ready(z_ready),
        .req_we(z_we), .req_addr(z_addr),
        .req_wdata(z_wdata), .req_be(z_be),
        .resp_valid(z_rvalid), .resp_ready(z_rready),
        .resp_rdata(z_rdata), .resp_err(z_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every response handshake against the queue head.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            logic [32:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected actual=%h_%h required=none", resp_err, resp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({resp_err, resp_rdata} !== e) begin
                    errors++;
                    $display("FAIL resp actual=%h_%h required=%h_%h",
                             resp_err, resp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] er, input logic ee,
                        output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        exp_q.push_back({ee, er});
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; resp_ready = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        z_valid = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0; z_rready = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, lat);
        chk("store_latency", 32'(lat), 32'd2);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, lat);
        chk("load_latency", 32'(lat), 32'd2);
        xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0, lat);
        xfer(1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 1'b0, lat);
        xfer(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, lat);
        xfer(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, lat);
        xfer(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, lat);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, lat);
        xfer(1'b1, 32'h0, 32'h12345678, 4'h0, 32'h0, 1'b0, lat);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, lat);
        xfer(1'b0, 32'h80000010, 32'h0, 4'h0, 32'h0, 1'b1, lat);
        xfer(1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0, 1'b0, lat);

        // Back-pressure with a second request already pending.
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        exp_q.push_back({1'b0, 32'hDE22BE44});
        @(posedge clk); #1;
        req_addr = 32'h0;
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'hDE22BE44);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_valid", 32'(resp_valid), 32'd0);
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        exp_q.push_back({1'b0, 32'hA5A5A5A5});
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("bp_pending_accepted", 32'(req_ready), 32'd0);
        lat = 0;
        while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
        chk("bp_pending_valid", 32'(resp_valid), 32'd1);
        @(posedge clk); #1;

        // Reset during the first WAIT cycle aborts the store.
        xfer(1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstwait_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstwait_req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("rstwait_still_idle", 32'(resp_valid), 32'd0);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, lat);

        // Zero-latency instance.
        @(negedge clk);
        z_valid = 1'b1; z_we = 1'b1; z_addr = 32'h8; z_wdata = 32'h0BADCAFE; z_be = 4'hF;
        chk("l0_ready", 32'(z_ready), 32'd1);
        @(posedge clk); #1 z_valid = 1'b0; z_we = 1'b0;
        @(negedge clk);
        chk("l0_store_valid", 32'(z_rvalid), 32'd1);
        chk("l0_store_err", 32'(z_err), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        z_valid = 1'b1; z_addr = 32'h8;
        chk("l0_ready2", 32'(z_ready), 32'd1);
        @(posedge clk); #1 z_valid = 1'b0;
        @(negedge clk);
        chk("l0_load_valid", 32'(z_rvalid), 32'd1);
        chk("l0_load_rdata", z_rdata, 32'h0BADCAFE);
        @(posedge clk); #1;

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
